// File: rtl/rv32im_mem_arbiter.sv
//------------------------------------------------------------------------------
// rv32im_mem_arbiter : two-requester (if/ls) single-port RAM arbiter,
// one transaction at a time. Optional macro: ARB_ROUND_ROBIN_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv32im_mem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic        if_we_i,
   input  logic [31:0] if_addr_i,
   input  logic [31:0] if_wdata_i,
   input  logic [3:0]  if_wmask_i,
   output logic        if_gnt_o,
   output logic        if_done_o,
   output logic [31:0] if_rdata_o,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   input  logic [3:0]  ls_wmask_i,
   output logic        ls_gnt_o,
   output logic        ls_done_o,
   output logic [31:0] ls_rdata_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wmask_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        owner_ls_q, owner_ls_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        pick_ls;

`ifdef ARB_ROUND_ROBIN_EN
   logic        prefer_ls_q, prefer_ls_d;

   // On contention the side that did not win last time is favoured.
   always_comb pick_ls = ls_req_i & (~if_req_i | prefer_ls_q);
`else
   always_comb pick_ls = ls_req_i;
`endif

   always_comb begin
      state_d    = state_q;
      owner_ls_d = owner_ls_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      if_gnt_o   = 1'b0;
      ls_gnt_o   = 1'b0;
      if_done_o  = 1'b0;
      ls_done_o  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prefer_ls_d = prefer_ls_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (if_req_i | ls_req_i) begin
               state_d    = ST_ACCESS;
               owner_ls_d = pick_ls;
               we_d       = pick_ls ? ls_we_i    : if_we_i;
               addr_d     = pick_ls ? ls_addr_i  : if_addr_i;
               wdata_d    = pick_ls ? ls_wdata_i : if_wdata_i;
               wmask_d    = pick_ls ? ls_wmask_i : if_wmask_i;
               if_gnt_o   = ~pick_ls;
               ls_gnt_o   = pick_ls;
`ifdef ARB_ROUND_ROBIN_EN
               prefer_ls_d = ~pick_ls;
`endif
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP: begin
            state_d = ST_IDLE;
            if (owner_ls_q) begin
               ls_done_o  = 1'b1;
               ls_rdata_d = mem_rdata_i;
            end else begin
               if_done_o  = 1'b1;
               if_rdata_d = mem_rdata_i;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A cycle with reset high neither grants nor completes anything.
      if (reset) begin
         if_gnt_o  = 1'b0;
         ls_gnt_o  = 1'b0;
         if_done_o = 1'b0;
         ls_done_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         owner_ls_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         wmask_q    <= 4'd0;
         if_rdata_q <= 32'd0;
         ls_rdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
         prefer_ls_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owner_ls_q <= owner_ls_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         prefer_ls_q <= prefer_ls_d;
`endif
      end
   end

   // Read data is visible in the completion cycle itself, then held.
   assign if_rdata_o  = if_rdata_d;
   assign ls_rdata_o  = ls_rdata_d;
   assign mem_en_o    = (state_q == ST_ACCESS);
   assign mem_we_o    = mem_en_o & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_wmask_o = mem_we_o ? wmask_q : 4'b0000;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/rv32im_mem_arbiter.md
RV32IM_MEM_ARBITER -- requirements
Module: rv32im_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have, per requester p in {if, ls}: p_req_i  input  1  access request, held until p_done_o.
REQ-004 SHALL have: p_we_i  input  1 (write=1); p_addr_i  input  32; p_wdata_i  input  32; p_wmask_i  input  4 (byte enables).
REQ-005 SHALL have: p_gnt_o  output  1  one-cycle grant pulse; p_done_o  output  1  one-cycle completion pulse; p_rdata_o  output  32  read data, valid with p_done_o.
REQ-006 SHALL have RAM side: mem_en_o  output  1; mem_we_o  output  1; mem_addr_o  output  32; mem_wdata_o  output  32; mem_wmask_o  output  4; mem_rdata_i  input  32, valid the cycle after mem_en_o.
REQ-007 SHALL have: busy_o  output  1  high in any state other than IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one outstanding transaction.
REQ-009 IDLE: if any req is high, select winner (REQ-013), latch its we/addr/wdata/wmask/owner, pulse winner's gnt_o, go ACCESS; otherwise stay IDLE.
REQ-010 ACCESS: mem_en_o=1 and mem_* driven from latched registers (not live inputs); mem_wmask_o forced 0000 for reads; unconditionally go RESP.
REQ-011 RESP: capture mem_rdata_i into owner's rdata_o, pulse owner's done_o, return to IDLE; non-owner rdata_o unchanged.
REQ-012 Latency: req sampled high in IDLE -> gnt same cycle -> done exactly 2 cycles later; peak throughput one access per 3 cycles.
REQ-013 Default priority: ls beats if when both request in IDLE.
REQ-014 A request deasserted after grant SHALL NOT abort; transaction completes and done_o still pulses.
REQ-015 A requester re-arbitrates in the IDLE cycle following its done_o; req still high that cycle counts as a new request.
REQ-016 gnt_o and done_o SHALL never be high for both requesters in the same cycle; mem_en_o high only in ACCESS.
REQ-017 Write transactions: done_o pulses in RESP; rdata_o for writes is undefined and ignored by requesters.
REQ-018 Inputs with req low SHALL have no effect.

Reset
REQ-019 On reset high at a rising edge: state=IDLE, all gnt_o/done_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o/mem_wdata_o=0, mem_wmask_o=0000, rdata_o=0, busy_o=0, RR pointer=if-favoured.
REQ-020 Reset mid-transaction SHALL drop it with no done_o pulse; it takes precedence over any FSM transition.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN: when defined, on contention grant the requester not granted last (pointer updates on every grant); when undefined, fixed ls priority of REQ-013 and no pointer register.

Verification
REQ-022 Single read: if_req=1, if_addr=0x10, RAM[0x10]=0xDEADBEEF -> if_gnt at T0, mem_en/mem_addr=0x10 at T1, if_done with if_rdata=0xDEADBEEF at T2.
REQ-023 Single write: ls_req=1, we=1, addr=0x4D0, wdata=0x12345678, wmask=1111 -> mem_we=1 at T1, ls_done at T2; subsequent read of 0x4D0 returns 0x12345678.
REQ-024 Contention, macro undefined: both req held 12 cycles -> grants ls,ls,ls,ls; if never granted.
REQ-025 Contention, ARB_ROUND_ROBIN_EN defined: both req held 12 cycles -> grants alternate if,ls,if,ls starting with if after reset.
REQ-026 Withdrawal: if_req high one cycle only -> done still pulses 2 cycles after gnt, then FSM stays IDLE.
REQ-027 Reset in ACCESS: assert reset one cycle -> no done pulse, mem_en=0, busy_o=0 next cycle; new request served normally afterwards.
